multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 272 +++++++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
// Moore control FSM for a multi-cycle MIPS-style datapath. Each instruction
// steps through FETCH, DECODE and one to three execution states, then returns
// to FETCH. Opcodes that are not recognised trap into HALT, and only reset
// leaves HALT.
//
// The control outputs are held in registers. On every edge they are loaded
// with the decode of the state being entered, so they always match the
// registered state. During reset they hold the FETCH decode.
//
// Ports
//   clk          in   1   rising-edge clock
//   rst_n        in   1   asynchronous active-low reset
//   opcode       in   6   IR[31:26]
//   funct        in   6   IR[5:0]
//   pcWrite      out  1   unconditional PC load
//   pcWriteCond  out  1   PC load if ALU zero
//   pcSource     out  2   0 ALU, 1 ALUOut, 2 jump target, 3 rs
//   iorD         out  1   memory address select (0 PC, 1 ALUOut)
//   memRead      out  1   memory read strobe
//   memWrite     out  1   memory write strobe
//   irWrite      out  1   IR load
//   regWrite     out  1   register file write strobe
//   regDst       out  2   0 rt, 1 rd, 2 $31
//   memToReg     out  2   0 ALUOut, 1 MDR, 2 PC
//   aluSrcA      out  1   0 PC, 1 A
//   aluSrcB      out  2   0 B, 1 const 4, 2 imm, 3 imm<<2
//   aluOp        out  2   0 add, 1 sub, 2 funct-decoded
//   state        out  4   current state code
//   halted       out  1   illegal instruction trap
//   instr_count  out 32   retired instruction count (wraps)
// ---------------------------------------------------------------------------
module multicycle_control (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    output logic        pcWrite,
    output logic        pcWriteCond,
    output logic [1:0]  pcSource,
    output logic        iorD,
    output logic        memRead,
    output logic        memWrite,
    output logic        irWrite,
    output logic        regWrite,
    output logic [1:0]  regDst,
    output logic [1:0]  memToReg,
    output logic        aluSrcA,
    output logic [1:0]  aluSrcB,
    output logic [1:0]  aluOp,
    output logic [3:0]  state,
    output logic        halted,
    output logic [31:0] instr_count
);

    typedef enum logic [3:0] {
        ST_FETCH     = 4'd0,
        ST_DECODE    = 4'd1,
        ST_MEM_ADDR  = 4'd2,
        ST_MEM_READ  = 4'd3,
        ST_MEM_WB    = 4'd4,
        ST_MEM_WRITE = 4'd5,
        ST_R_EXEC    = 4'd6,
        ST_R_WB      = 4'd7,
        ST_BRANCH    = 4'd8,
        ST_JUMP      = 4'd9,
        ST_JR        = 4'd10,
        ST_I_EXEC    = 4'd11,
        ST_I_WB      = 4'd12,
        ST_JAL       = 4'd13,
        ST_HALT      = 4'd14
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       ior_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       halted;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] FN_JR    = 6'b001000;

    state_t      r_state;
    ctrl_t       r_ctrl;
    logic [31:0] r_instr_count;
    state_t      w_next_state;

    // Transition function. State 3 with a non-lw opcode and the unused code 15
    // both fall back to FETCH so a corrupted state cannot lock the machine.
    function automatic state_t next_state_f(input state_t s,
                                            input logic [5:0] op,
                                            input logic [5:0] fn);
        state_t ns;
        ns = ST_FETCH;
        case (s)
            ST_FETCH:    ns = ST_DECODE;
            ST_DECODE: begin
                case (op)
                    OP_RTYPE: begin
                        if (fn == FN_JR) ns = ST_JR;
                        else             ns = ST_R_EXEC;
                    end
                    OP_LW, OP_SW: ns = ST_MEM_ADDR;
                    OP_BEQ:       ns = ST_BRANCH;
                    OP_J:         ns = ST_JUMP;
                    OP_JAL:       ns = ST_JAL;
                    OP_ADDI:      ns = ST_I_EXEC;
                    default:      ns = ST_HALT;
                endcase
            end
            ST_MEM_ADDR: begin
                if (op == OP_LW) ns = ST_MEM_READ;
                else             ns = ST_MEM_WRITE;
            end
            ST_MEM_READ: begin
                if (op == OP_LW) ns = ST_MEM_WB;
                else             ns = ST_FETCH;
            end
            ST_R_EXEC:   ns = ST_R_WB;
            ST_I_EXEC:   ns = ST_I_WB;
            ST_HALT:     ns = ST_HALT;
            ST_MEM_WB, ST_MEM_WRITE, ST_R_WB, ST_BRANCH,
            ST_JUMP, ST_JR, ST_JAL, ST_I_WB:
                         ns = ST_FETCH;
            default:     ns = ST_FETCH;
        endcase
        return ns;
    endfunction

    // An instruction retires only when it leaves one of these states for
    // FETCH. Recovery out of a corrupted state does not count.
    function automatic logic is_terminal_f(input state_t s);
        logic t;
        case (s)
            ST_MEM_WB, ST_MEM_WRITE, ST_R_WB, ST_BRANCH,
            ST_JUMP, ST_JR, ST_JAL, ST_I_WB: t = 1'b1;
            default:                         t = 1'b0;
        endcase
        return t;
    endfunction

    // Moore output table. Any field not set for a state stays 0.
    function automatic ctrl_t decode_f(input state_t s);
        ctrl_t c;
        c = ctrl_t'(19'd0);
        case (s)
            ST_FETCH: begin
                c.mem_read  = 1'b1;
                c.ir_write  = 1'b1;
                c.alu_src_b = 2'd1;
                c.pc_write  = 1'b1;
                c.pc_source = 2'd0;
            end
            ST_DECODE:    c.alu_src_b = 2'd3;
            ST_MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'd2;
            end
            ST_MEM_READ: begin
                c.mem_read = 1'b1;
                c.ior_d    = 1'b1;
            end
            ST_MEM_WB: begin
                c.reg_write  = 1'b1;
                c.reg_dst    = 2'd0;
                c.mem_to_reg = 2'd1;
            end
            ST_MEM_WRITE: begin
                c.mem_write = 1'b1;
                c.ior_d     = 1'b1;
            end
            ST_R_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'd2;
            end
            ST_R_WB: begin
                c.reg_write  = 1'b1;
                c.reg_dst    = 2'd1;
                c.mem_to_reg = 2'd0;
            end
            ST_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = 2'd1;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 2'd1;
            end
            ST_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = 2'd2;
            end
            ST_JR: begin
                c.pc_write  = 1'b1;
                c.pc_source = 2'd3;
            end
            ST_I_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'd2;
            end
            ST_I_WB: begin
                c.reg_write  = 1'b1;
                c.reg_dst    = 2'd0;
                c.mem_to_reg = 2'd0;
            end
            ST_JAL: begin
                c.reg_write  = 1'b1;
                c.reg_dst    = 2'd2;
                c.mem_to_reg = 2'd2;
                c.pc_write   = 1'b1;
                c.pc_source  = 2'd2;
            end
            ST_HALT:  c.halted = 1'b1;
            default:  c = ctrl_t'(19'd0);
        endcase
        return c;
    endfunction

    assign w_next_state = next_state_f(r_state, opcode, funct);

    // State register, registered control outputs and retire counter. Reset
    // acts at once: it abandons any partial instruction and clears the trap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_FETCH;
            r_ctrl        <= decode_f(ST_FETCH);
            r_instr_count <= 32'd0;
        end else begin
            r_state <= w_next_state;
            r_ctrl  <= decode_f(w_next_state);
            if (is_terminal_f(r_state) && (w_next_state == ST_FETCH)) begin
                r_instr_count <= r_instr_count + 32'd1;
            end else begin
                r_instr_count <= r_instr_count;
            end
        end
    end

    assign pcWrite     = r_ctrl.pc_write;
    assign pcWriteCond = r_ctrl.pc_write_cond;
    assign pcSource    = r_ctrl.pc_source;
    assign iorD        = r_ctrl.ior_d;
    assign memRead     = r_ctrl.mem_read;
    assign memWrite    = r_ctrl.mem_write;
    assign irWrite     = r_ctrl.ir_write;
    assign regWrite    = r_ctrl.reg_write;
    assign regDst      = r_ctrl.reg_dst;
    assign memToReg    = r_ctrl.mem_to_reg;
    assign aluSrcA     = r_ctrl.alu_src_a;
    assign aluSrcB     = r_ctrl.alu_src_b;
    assign aluOp       = r_ctrl.alu_op;
    assign halted      = r_ctrl.halted;
    assign state       = r_state;
    assign instr_count = r_instr_count;

endmodule

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control
// Self-checking bench for multicycle_control. A table of instruction records
// holds the opcode, the funct field and the expected state walk. When an
// instruction is driven, its expected states go into a scoreboard queue.
// Each cycle the bench pops one state and checks the DUT's state, its full
// output vector (against an independent output table) and instr_count.
// Separate hand-written sequences cover the trap, a reset in the middle of
// an instruction, and counter wrap.
// ---------------------------------------------------------------------------
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  opcode = 6'd0;
    logic [5:0]  funct = 6'd0;
    logic        pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
    logic        regWrite, aluSrcA, halted;
    logic [1:0]  pcSource, regDst, memToReg, aluSrcB, aluOp;
    logic [3:0]  state;
    logic [31:0] instr_count;
    logic [18:0] w_ctrl;

    multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
        .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .pcSource(pcSource),
        .iorD(iorD), .memRead(memRead), .memWrite(memWrite),
        .irWrite(irWrite), .regWrite(regWrite), .regDst(regDst),
        .memToReg(memToReg), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB),
        .aluOp(aluOp), .state(state), .halted(halted),
        .instr_count(instr_count)
    );

    assign w_ctrl = {pcWrite, pcWriteCond, pcSource, iorD, memRead, memWrite,
                     irWrite, regWrite, regDst, memToReg, aluSrcA, aluSrcB,
                     aluOp, halted};

    // 100 MHz clock
    always #5 clk = ~clk;

    // Bounded runtime guard
    initial begin
        #50000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [2:0]  len;
        logic [23:0] seq;   // nibble i = i-th expected state from FETCH
    } vec_t;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_count = 32'd0;
    logic [3:0]  sb_q[$];

    // Expected outputs per state, in the same bit order as w_ctrl.
    function automatic logic [18:0] model(input logic [3:0] s);
        logic pw, pwc, iord, mr, mw, irw, rw, asa, h;
        logic [1:0] ps, rd, m2r, asb, aop;
        {pw, pwc, iord, mr, mw, irw, rw, asa, h} = 9'd0;
        {ps, rd, m2r, asb, aop} = 10'd0;
        case (s)
            4'd0:  begin mr = 1'b1; irw = 1'b1; asb = 2'd1; pw = 1'b1; ps = 2'd0; end
            4'd1:  asb = 2'd3;
            4'd2:  begin asa = 1'b1; asb = 2'd2; end
            4'd3:  begin mr = 1'b1; iord = 1'b1; end
            4'd4:  begin rw = 1'b1; rd = 2'd0; m2r = 2'd1; end
            4'd5:  begin mw = 1'b1; iord = 1'b1; end
            4'd6:  begin asa = 1'b1; aop = 2'd2; end
            4'd7:  begin rw = 1'b1; rd = 2'd1; m2r = 2'd0; end
            4'd8:  begin asa = 1'b1; aop = 2'd1; pwc = 1'b1; ps = 2'd1; end
            4'd9:  begin pw = 1'b1; ps = 2'd2; end
            4'd10: begin pw = 1'b1; ps = 2'd3; end
            4'd11: begin asa = 1'b1; asb = 2'd2; end
            4'd12: begin rw = 1'b1; rd = 2'd0; m2r = 2'd0; end
            4'd13: begin rw = 1'b1; rd = 2'd2; m2r = 2'd2; pw = 1'b1; ps = 2'd2; end
            4'd14: h = 1'b1;
            default: h = 1'b0;
        endcase
        return {pw, pwc, ps, iord, mr, mw, irw, rw, rd, m2r, asa, asb, aop, h};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Pop one expected state and compare state, outputs and counter.
    task automatic check_cycle(input string tag);
        logic [3:0] e;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s scoreboard: got empty queue, expected an entry", tag);
        end else begin
            e = sb_q.pop_front();
            chk({tag, " state"}, 32'(state), 32'(e));
            chk({tag, " ctrl"}, 32'(w_ctrl), 32'(model(e)));
            chk({tag, " count"}, instr_count, exp_count);
        end
    endtask

    // Drive one instruction from FETCH and follow it back to FETCH.
    task automatic run_vec(input vec_t v, input string tag);
        opcode = v.op;
        funct  = v.fn;
        for (int i = 0; i < int'(v.len); i++) sb_q.push_back(v.seq[4*i +: 4]);
        for (int i = 0; i < int'(v.len); i++) begin
            #2;
            check_cycle(tag);
            @(posedge clk);
        end
        exp_count = exp_count + 32'd1;
        #2;
        chk({tag, " back to FETCH"}, 32'(state), 32'd0);
        chk({tag, " retired"}, instr_count, exp_count);
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = '{op: 6'h23, fn: 6'h00, len: 3'd5, seq: 24'h043210}; // lw
        vecs[1] = '{op: 6'h2B, fn: 6'h00, len: 3'd4, seq: 24'h005210}; // sw
        vecs[2] = '{op: 6'h00, fn: 6'h20, len: 3'd4, seq: 24'h007610}; // add
        vecs[3] = '{op: 6'h00, fn: 6'h08, len: 3'd3, seq: 24'h000A10}; // jr
        vecs[4] = '{op: 6'h04, fn: 6'h00, len: 3'd3, seq: 24'h000810}; // beq
        vecs[5] = '{op: 6'h02, fn: 6'h00, len: 3'd3, seq: 24'h000910}; // j
        vecs[6] = '{op: 6'h03, fn: 6'h00, len: 3'd3, seq: 24'h000D10}; // jal
        vecs[7] = '{op: 6'h08, fn: 6'h08, len: 3'd4, seq: 24'h00CB10}; // addi, jr-like funct
        vecs[8] = '{op: 6'h00, fn: 6'h09, len: 3'd4, seq: 24'h007610}; // R-type, funct next to jr

        // Reset state, observed while rst_n is still low and the clock runs
        #12;
        chk("reset state", 32'(state), 32'd0);
        chk("reset ctrl", 32'(w_ctrl), 32'(model(4'd0)));
        chk("reset count", instr_count, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 9; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

        // Reset in state 3 of a lw, between clock edges
        opcode = 6'h23;
        funct  = 6'h00;
        sb_q.push_back(4'd0); sb_q.push_back(4'd1);
        sb_q.push_back(4'd2); sb_q.push_back(4'd3);
        for (int i = 0; i < 3; i++) begin
            #2;
            check_cycle("midrst");
            @(posedge clk);
        end
        #2;
        check_cycle("midrst");
        rst_n = 1'b0;
        exp_count = 32'd0;
        #1;
        chk("midrst async state", 32'(state), 32'd0);
        chk("midrst async count", instr_count, 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk("midrst no regWrite", 32'(regWrite), 32'd0);
            chk("midrst held FETCH", 32'(state), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(vecs[7], "post-rst addi");

        // Illegal opcode: trap and hold, then an asynchronous reset pulse
        opcode = 6'h3F;
        sb_q.push_back(4'd0); sb_q.push_back(4'd1);
        for (int i = 0; i < 12; i++) sb_q.push_back(4'd14);
        for (int i = 0; i < 14; i++) begin
            #2;
            check_cycle("halt");
            @(posedge clk);
        end
        #2;
        rst_n = 1'b0;
        exp_count = 32'd0;
        #1;
        chk("halt rst state", 32'(state), 32'd0);
        chk("halt rst halted", 32'(halted), 32'd0);
        chk("halt rst count", instr_count, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Counter wrap across a sw
        force dut.r_instr_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_instr_count;
        exp_count = 32'hFFFF_FFFF;
        run_vec(vecs[1], "wrap sw");
        run_vec(vecs[5], "after wrap j");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
